// File: rtl/decode_stage.sv
// decode_stage: MIPS D-stage with F/D register, bypassed GRF, forwarding, branch/jump resolution
module decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_EN,
  input  logic [31:0] v_PC_I,
  input  logic [31:0] instrI,
  input  logic        W_WE,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_WD,
  input  logic [1:0]  FWD_RS_SEL,
  input  logic [1:0]  FWD_RT_SEL,
  input  logic [31:0] v_M_fwd,
  input  logic [31:0] v_E_fwd,
  output logic [31:0] v_PC_D,
  output logic [31:0] instrD,
  output logic [31:0] v_RS_D,
  output logic [31:0] v_RT_D,
  output logic [31:0] v_EXT_D,
  output logic        b_taken,
  output logic [31:0] v_NPC
);
  logic [31:0] r_pc, r_instr;
  logic [31:0] r_grf [32];
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt;
  logic [15:0] w_imm;
  logic [31:0] w_rs_grf, w_rt_grf, w_br_off;
  logic        w_wr, w_br, w_j, w_jr;
  assign w_op  = r_instr[31:26];
  assign w_rs  = r_instr[25:21];
  assign w_rt  = r_instr[20:16];
  assign w_imm = r_instr[15:0];
  assign w_wr  = W_WE && (W_A3 != 5'd0);
  // F/D pipeline register; D_EN low holds the current instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= PC_RESET;
      r_instr <= '0;
    end else if (D_EN) begin
      r_pc    <= v_PC_I;
      r_instr <= instrI;
    end
  end
  // register file; $0 is never written so it stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_grf[i] <= '0;
    end else if (w_wr) begin
      r_grf[W_A3] <= W_WD;
    end
  end
  // write-first read: a same-cycle W-stage write is visible immediately
  assign w_rs_grf = (w_rs == 5'd0) ? '0 : (w_wr && W_A3 == w_rs) ? W_WD : r_grf[w_rs];
  assign w_rt_grf = (w_rt == 5'd0) ? '0 : (w_wr && W_A3 == w_rt) ? W_WD : r_grf[w_rt];
  assign v_RS_D = (FWD_RS_SEL == 2'd1) ? v_M_fwd : (FWD_RS_SEL == 2'd2) ? v_E_fwd : w_rs_grf;
  assign v_RT_D = (FWD_RT_SEL == 2'd1) ? v_M_fwd : (FWD_RT_SEL == 2'd2) ? v_E_fwd : w_rt_grf;
  assign v_EXT_D = (w_op == 6'b001101) ? {16'h0, w_imm} :
                   (w_op == 6'b001111) ? {w_imm, 16'h0} : {{16{w_imm[15]}}, w_imm};
  assign w_br_off = {{14{w_imm[15]}}, w_imm, 2'b00};
  assign w_br = ((w_op == 6'b000100) && (v_RS_D == v_RT_D)) ||
                ((w_op == 6'b000101) && (v_RS_D != v_RT_D));
  assign w_j  = (w_op == 6'b000010) || (w_op == 6'b000011);
  assign w_jr = (w_op == 6'b000000) && (r_instr[5:0] == 6'b001000);
  assign b_taken = w_br || w_j || w_jr;
  assign v_NPC = w_br ? r_pc + 32'd4 + w_br_off :
                 w_j  ? {r_pc[31:28], r_instr[25:0], 2'b00} :
                 w_jr ? v_RS_D : v_PC_I + 32'd4;
  assign v_PC_D = r_pc;
  assign instrD = r_instr;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table + scoreboard checks of decode_stage
module tb_decode_stage;
  logic        clk = 0, reset = 1, D_EN = 0, W_WE = 0;
  logic [31:0] v_PC_I = 0, instrI = 0, W_WD = 0, v_M_fwd = 0, v_E_fwd = 0;
  logic [4:0]  W_A3 = 0;
  logic [1:0]  FWD_RS_SEL = 0, FWD_RT_SEL = 0;
  logic [31:0] v_PC_D, instrD, v_RS_D, v_RT_D, v_EXT_D, v_NPC;
  logic        b_taken;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [31:0] instr, pc, pci, m, e;
    logic [1:0]  rss, rts;
    logic [31:0] x_rs, x_rt, x_ext;
    logic        x_tk;
    logic [31:0] x_npc;
  } vec_t;

  vec_t tbl[17];
  vec_t sb[$];

  decode_stage dut (
    .clk(clk), .reset(reset), .D_EN(D_EN), .v_PC_I(v_PC_I), .instrI(instrI),
    .W_WE(W_WE), .W_A3(W_A3), .W_WD(W_WD), .FWD_RS_SEL(FWD_RS_SEL), .FWD_RT_SEL(FWD_RT_SEL),
    .v_M_fwd(v_M_fwd), .v_E_fwd(v_E_fwd), .v_PC_D(v_PC_D), .instrD(instrD),
    .v_RS_D(v_RS_D), .v_RT_D(v_RT_D), .v_EXT_D(v_EXT_D), .b_taken(b_taken), .v_NPC(v_NPC)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  // called #1 after a posedge
  task automatic wr(logic [4:0] a, logic [31:0] d);
    W_WE = 1; W_A3 = a; W_WD = d;
    @(posedge clk); #1;
    W_WE = 0;
  endtask

  task automatic load(logic [31:0] pc, logic [31:0] ins);
    D_EN = 1; v_PC_I = pc; instrI = ins;
    @(posedge clk); #1;
    D_EN = 0;
  endtask

  task automatic run_vec(int i);
    vec_t v, x;
    v = tbl[i];
    load(v.pc, v.instr);
    v_PC_I = v.pci; FWD_RS_SEL = v.rss; FWD_RT_SEL = v.rts; v_M_fwd = v.m; v_E_fwd = v.e;
    sb.push_back(v);
    @(negedge clk);
    x = sb.pop_front();
    chk($sformatf("v%0d.pcD", i), v_PC_D, x.pc);
    chk($sformatf("v%0d.instrD", i), instrD, x.instr);
    chk($sformatf("v%0d.rs", i), v_RS_D, x.x_rs);
    chk($sformatf("v%0d.rt", i), v_RT_D, x.x_rt);
    chk($sformatf("v%0d.ext", i), v_EXT_D, x.x_ext);
    chk($sformatf("v%0d.taken", i), {31'b0, b_taken}, {31'b0, x.x_tk});
    chk($sformatf("v%0d.npc", i), v_NPC, x.x_npc);
    @(posedge clk); #1;
  endtask

  initial begin
    //         instr                         pc            pci           m      e           rss   rts   rs           rt     ext            tk    npc
    tbl[0]  = '{mk(6'h00, 9, 9, 16'h1021),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd0, 32'd5,       32'd5, 32'h00001021, 1'b0, 32'h3008};
    tbl[1]  = '{mk(6'h00, 9, 9, 16'h1021),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd1, 32'd5,       32'd7, 32'h00001021, 1'b0, 32'h3008};
    tbl[2]  = '{mk(6'h00, 9, 9, 16'h1021),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd2, 32'd5,       32'd9, 32'h00001021, 1'b0, 32'h3008};
    tbl[3]  = '{mk(6'h00, 9, 9, 16'h1021),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd3, 32'd5,       32'd5, 32'h00001021, 1'b0, 32'h3008};
    tbl[4]  = '{mk(6'h04, 9, 10, 16'hFFFF), 32'h3004,     32'h3008,     32'd7, 32'd9,      2'd0, 2'd0, 32'd5,       32'd5, 32'hFFFFFFFF, 1'b1, 32'h3004};
    tbl[5]  = '{mk(6'h04, 9, 11, 16'hFFFF), 32'h3004,     32'h3008,     32'd7, 32'd9,      2'd0, 2'd0, 32'd5,       32'd6, 32'hFFFFFFFF, 1'b0, 32'h300C};
    tbl[6]  = '{mk(6'h05, 9, 10, 16'hFFFF), 32'h3004,     32'h3008,     32'd7, 32'd9,      2'd0, 2'd0, 32'd5,       32'd5, 32'hFFFFFFFF, 1'b0, 32'h300C};
    tbl[7]  = '{mk(6'h05, 9, 11, 16'hFFFF), 32'h3004,     32'h3008,     32'd7, 32'd9,      2'd0, 2'd0, 32'd5,       32'd6, 32'hFFFFFFFF, 1'b1, 32'h3004};
    tbl[8]  = '{mk(6'h03, 0, 0, 16'h0C03),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd0, 32'd0,       32'd0, 32'h00000C03, 1'b1, 32'h300C};
    tbl[9]  = '{mk(6'h00, 12, 0, 16'h0008), 32'h3010,     32'h3014,     32'd7, 32'h3040,   2'd2, 2'd0, 32'h3040,    32'd0, 32'h00000008, 1'b1, 32'h3040};
    tbl[10] = '{mk(6'h0D, 0, 0, 16'h8000),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd0, 32'd0,       32'd0, 32'h00008000, 1'b0, 32'h3008};
    tbl[11] = '{mk(6'h0F, 0, 0, 16'h8000),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd0, 32'd0,       32'd0, 32'h80000000, 1'b0, 32'h3008};
    tbl[12] = '{mk(6'h09, 0, 0, 16'h8000),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd0, 32'd0,       32'd0, 32'hFFFF8000, 1'b0, 32'h3008};
    tbl[13] = '{mk(6'h04, 0, 0, 16'h0010),  32'h3020,     32'h3024,     32'd7, 32'd9,      2'd1, 2'd0, 32'd7,       32'd0, 32'h00000010, 1'b0, 32'h3028};
    tbl[14] = '{mk(6'h04, 0, 0, 16'h0001),  32'hFFFFFFF8, 32'hFFFFFFFC, 32'd7, 32'd9,      2'd0, 2'd0, 32'd0,       32'd0, 32'h00000001, 1'b1, 32'h00000000};
    tbl[15] = '{mk(6'h3F, 0, 0, 16'h8000),  32'h3000,     32'h3004,     32'd7, 32'd9,      2'd0, 2'd0, 32'd0,       32'd0, 32'hFFFF8000, 1'b0, 32'h3008};
    tbl[16] = '{mk(6'h02, 31, 31, 16'hFFFF), 32'h90000000, 32'h90000004, 32'd7, 32'd9,     2'd0, 2'd0, 32'd0,       32'd0, 32'hFFFFFFFF, 1'b1, 32'h9FFFFFFC};

    // reset state
    v_PC_I = 32'h100; instrI = mk(6'h04, 0, 0, 16'h0004); D_EN = 1;
    #12;
    chk("rst.instrD", instrD, 32'h0);
    chk("rst.pcD", v_PC_D, 32'h3000);
    chk("rst.npc", v_NPC, 32'h104);
    chk("rst.taken", {31'b0, b_taken}, 32'h0);
    @(posedge clk); #1;
    reset = 0; D_EN = 0;
    wr(9, 5); wr(10, 5); wr(11, 6);

    for (int i = 0; i < 17; i++) run_vec(i);
    FWD_RS_SEL = 0; FWD_RT_SEL = 0;

    // same-cycle bypass, then persisted value
    load(32'h3000, mk(6'h00, 8, 0, 16'h0021));
    W_WE = 1; W_A3 = 8; W_WD = 32'h1234;
    @(negedge clk);
    chk("byp.same", v_RS_D, 32'h1234);
    @(posedge clk); #1;
    W_WE = 0; W_WD = 32'hDEAD;
    @(negedge clk);
    chk("byp.next", v_RS_D, 32'h1234);
    @(posedge clk); #1;
    // writes to $0 are ignored, bypass included
    load(32'h3000, mk(6'h00, 0, 8, 16'h0021));
    W_WE = 1; W_A3 = 0; W_WD = 32'hFFFF;
    @(negedge clk);
    chk("r0.same", v_RS_D, 32'h0);
    @(posedge clk); #1;
    W_WE = 0;
    @(negedge clk);
    chk("r0.next", v_RS_D, 32'h0);
    chk("r0.rt8", v_RT_D, 32'h1234);
    @(posedge clk); #1;

    // stall holds F/D for three cycles
    load(32'h3050, mk(6'h09, 1, 2, 16'h0042));
    for (int k = 0; k < 3; k++) begin
      v_PC_I = 32'h4000 + 32'(k * 4); instrI = 32'hA5A5_0000 + 32'(k);
      @(posedge clk); #1;
      chk($sformatf("stall%0d.instrD", k), instrD, mk(6'h09, 1, 2, 16'h0042));
      chk($sformatf("stall%0d.pcD", k), v_PC_D, 32'h3050);
      chk($sformatf("stall%0d.npc", k), v_NPC, 32'h4000 + 32'(k * 4) + 32'd4);
    end
    load(32'h3054, mk(6'h0D, 0, 0, 16'h0001));
    chk("unstall.pcD", v_PC_D, 32'h3054);

    // asynchronous reset mid-cycle clears F/D and GRF
    load(32'h3060, mk(6'h04, 9, 11, 16'h0003));
    v_PC_I = 32'h3064;
    @(negedge clk); #2;
    reset = 1;
    #1;
    chk("arst.instrD", instrD, 32'h0);
    chk("arst.pcD", v_PC_D, 32'h3000);
    chk("arst.npc", v_NPC, 32'h3068);
    #1 reset = 0;
    @(posedge clk); #1;
    load(32'h3000, mk(6'h00, 9, 10, 16'h0021));
    chk("arst.r9", v_RS_D, 32'h0);
    chk("arst.r10", v_RT_D, 32'h0);
    load(32'h3000, mk(6'h00, 11, 8, 16'h0021));
    chk("arst.r11", v_RS_D, 32'h0);
    chk("arst.r8", v_RT_D, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
